// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract sequencer:
//   FSM state encodings and the default datapath width.
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

   localparam int SA_DATA_W = 32;

   localparam logic [1:0] SA_IDLE = 2'b00;
   localparam logic [1:0] SA_RUN  = 2'b01;
   localparam logic [1:0] SA_DONE = 2'b10;

endpackage

// File: rtl/serial_add_shreg.sv
// -----------------------------------------------------------------------------
// serial_add_shreg
//   WIDTH-bit right-shift register with parallel load.
//   Ports:
//     clk_i       clock, rising edge
//     rst_i       synchronous active-high reset (clears to 0)
//     load_i      parallel load of load_val_i (wins over shift)
//     shift_i     shift right by one, shift_in_i enters at the MSB
//     load_val_i  parallel load value
//     shift_in_i  serial input bit
//     q_o         register contents
// -----------------------------------------------------------------------------
module serial_add_shreg #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             shift_in_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load_i)       sh_d = load_val_i;
      else if (shift_i) sh_d = {shift_in_i, sh_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) sh_q <= '0;
      else       sh_q <= sh_d;
   end

   assign q_o = sh_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract sequencer. Time-shares one external combinational
//   FULL_ADDER over WIDTH cycles, LSB first, and returns S/CO/OVF with a
//   one-cycle DONE pulse.
//   Ports:
//     CLK, RST         clock / synchronous active-high reset
//     START            request, accepted in IDLE or DONE only
//     SUB              0: A+B, 1: A-B (sampled with START)
//     A, B             operands (sampled with START)
//     FA_S, FA_CO      sum / carry back from the shared FULL_ADDER
//     FA_A, FA_B, FA_CI  bit pair and carry driven to the FULL_ADDER
//     BUSY             high while in RUN
//     DONE             one-cycle result-valid pulse
//     S, CO, OVF       result, final carry (SUB: 1 = no borrow), signed overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = SA_DATA_W,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             FA_S,
   input  logic             FA_CO,
   output logic             FA_A,
   output logic             FA_B,
   output logic             FA_CI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] S,
   output logic             CO,
   output logic             OVF
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic             running, last, accept, step;

   assign running = (state_q == SA_RUN);
   assign last    = (cnt_q == CNT_W'(WIDTH - 1));
   // START is only honoured outside RUN; a request mid-operation is dropped.
   assign accept  = START && ((state_q == SA_IDLE) || (state_q == SA_DONE));
   // No shift on the final bit: the last sum bit goes straight into S.
   assign step    = running && !last;

   // Subtraction is A + ~B + 1: invert B at load and seed the carry with SUB.
   serial_add_shreg #(.WIDTH(WIDTH)) u_a_sh (
      .clk_i(CLK), .rst_i(RST), .load_i(accept), .shift_i(step),
      .load_val_i(A), .shift_in_i(1'b0), .q_o(a_sh)
   );

   serial_add_shreg #(.WIDTH(WIDTH)) u_b_sh (
      .clk_i(CLK), .rst_i(RST), .load_i(accept), .shift_i(step),
      .load_val_i(SUB ? ~B : B), .shift_in_i(1'b0), .q_o(b_sh)
   );

   // Sum bits enter at the MSB so after WIDTH-1 shifts bit i sits at r_sh[i+1].
   serial_add_shreg #(.WIDTH(WIDTH)) u_r_sh (
      .clk_i(CLK), .rst_i(RST), .load_i(accept), .shift_i(step),
      .load_val_i('0), .shift_in_i(FA_S), .q_o(r_sh)
   );

   // Only the serial ends of the shifters are consumed.
   logic unused_bits;
   assign unused_bits = ^{r_sh[0], a_sh[WIDTH-1:1], b_sh[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      s_d     = s_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      case (state_q)
         SA_IDLE, SA_DONE: begin
            if (START) begin
               state_d = SA_RUN;
               cnt_d   = '0;
               carry_d = SUB;
            end else begin
               state_d = SA_IDLE;
            end
         end
         SA_RUN: begin
            if (last) begin
               state_d = SA_DONE;
               s_d     = {FA_S, r_sh[WIDTH-1:1]};
               co_d    = FA_CO;
               // carry_q is the carry into the MSB on this final bit.
               ovf_d   = carry_q ^ FA_CO;
            end else begin
               carry_d = FA_CO;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = SA_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= SA_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   assign FA_A  = running & a_sh[0];
   assign FA_B  = running & b_sh[0];
   assign FA_CI = running & carry_q;
   assign BUSY  = running;
   assign DONE  = (state_q == SA_DONE);
   assign S     = s_q;
   assign CO    = co_q;
   assign OVF   = ovf_q;

endmodule
